aes128_dec_iter: RTL and testbench

AES128_DEC_ITER -- requirements
Module: aes128_dec_iter

---
 rtl/aes_pkg.sv | 91 +++++++++
 rtl/aes_inv_round.sv | 58 +++++
 rtl/aes128_dec_iter.sv | 102 ++++++++++
 tb/tb_aes128_dec_iter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants: S-box tables, Rcon, FSM state encoding and round count.
package aes_pkg;

    localparam int unsigned NUM_ROUNDS = 10;

    typedef enum logic [1:0] {
        StIdle,
        StRound,
        StDone
    } dec_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
        8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
        8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
        8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
        8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
        8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
        8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
        8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
        8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
        8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
        8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
        8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
        8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
        8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
        8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
        8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
        8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // RCON[i] belongs to round i+1.
    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One AES inverse round, purely combinational: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless skip_mix_i is set (final round).
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] round_key_i,
    input  logic         skip_mix_i,
    output logic [127:0] state_o
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // GF(2^8) multiply by a constant of at most 4 bits.
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] m);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (m[0] ? b : 8'h00) ^ (m[1] ? x2 : 8'h00) ^
               (m[2] ? x4 : 8'h00) ^ (m[3] ? x8 : 8'h00);
    endfunction

    // Element 0 is byte 0 (bits 127:120); byte n sits at row n%4, column n/4.
    logic [0:15][7:0] in_b, sub_b, add_b, mix_b;

    assign in_b = state_i;

    always_comb begin
        sub_b = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sub_b[4 * c + r] = INV_SBOX[in_b[4 * ((c + 4 - r) % 4) + r]];
            end
        end
    end

    assign add_b = sub_b ^ round_key_i;

    always_comb begin
        mix_b = '0;
        for (int c = 0; c < 4; c++) begin
            mix_b[4 * c + 0] = gmul(add_b[4 * c], 4'he) ^ gmul(add_b[4 * c + 1], 4'hb) ^
                               gmul(add_b[4 * c + 2], 4'hd) ^ gmul(add_b[4 * c + 3], 4'h9);
            mix_b[4 * c + 1] = gmul(add_b[4 * c], 4'h9) ^ gmul(add_b[4 * c + 1], 4'he) ^
                               gmul(add_b[4 * c + 2], 4'hb) ^ gmul(add_b[4 * c + 3], 4'hd);
            mix_b[4 * c + 2] = gmul(add_b[4 * c], 4'hd) ^ gmul(add_b[4 * c + 1], 4'h9) ^
                               gmul(add_b[4 * c + 2], 4'he) ^ gmul(add_b[4 * c + 3], 4'hb);
            mix_b[4 * c + 3] = gmul(add_b[4 * c], 4'hb) ^ gmul(add_b[4 * c + 1], 4'hd) ^
                               gmul(add_b[4 * c + 2], 4'h9) ^ gmul(add_b[4 * c + 3], 4'he);
        end
    end

    assign state_o = skip_mix_i ? add_b : mix_b;

endmodule

// File: rtl/aes128_dec_iter.sv
// Iterative AES-128 decryptor, one round per cycle, one block in flight.
// Define AES128_DEC_KEYOUT_EN to expose the recovered cipher key on port key0.
module aes128_dec_iter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ct,
    input  logic [127:0] key10,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] pt,
`ifdef AES128_DEC_KEYOUT_EN
    output logic [127:0] key0,
`endif
    output logic         busy
);

    dec_state_e   state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] data_q, data_d;
    logic [127:0] key_q, key_d;
    logic [127:0] round_key, round_out;
    logic [31:0]  w0, w1, w2, w3, w0_n, w1_n, w2_n, w3_n;
    logic         accept;

    assign in_ready  = !rst && (state_q == StIdle);
    assign out_valid = !rst && (state_q == StDone);
    assign busy      = !rst && (state_q == StRound);
    assign accept    = in_valid && in_ready;
    assign pt        = data_q;

`ifdef AES128_DEC_KEYOUT_EN
    assign key0 = key_q;
`endif

    // Inverse key schedule: k_r from k_(r+1); counter r selects Rcon(r+1).
    always_comb begin
        {w0, w1, w2, w3} = key_q;
        w3_n = w3 ^ w2;
        w2_n = w2 ^ w1;
        w1_n = w1 ^ w0;
        w0_n = w0 ^ sub_word({w3_n[23:0], w3_n[31:24]}) ^ {RCON[cnt_q], 24'h0};
        round_key = {w0_n, w1_n, w2_n, w3_n};
    end

    aes_inv_round u_inv_round (
        .state_i     (data_q),
        .round_key_i (round_key),
        .skip_mix_i  (cnt_q == 4'd0),
        .state_o     (round_out)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        key_d   = key_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StRound;
                    data_d  = ct ^ key10;
                    key_d   = key10;
                    cnt_d   = 4'(NUM_ROUNDS - 1);
                end
            end
            StRound: begin
                data_d = round_out;
                key_d  = round_key;
                if (cnt_q == 4'd0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            data_q  <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            key_q   <= key_d;
        end
    end

endmodule

// File: tb/tb_aes128_dec_iter.sv
// Directed scoreboard bench for aes128_dec_iter using FIPS-197 known-answer vectors.
module tb_aes128_dec_iter;

    localparam logic [127:0] C1_KEY10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] C1_CT    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_KEY0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] B_KEY10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] B_CT     = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT     = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY0   = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    typedef struct packed {
        logic [127:0] pt;
        logic [127:0] key;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] ct = '0;
    logic [127:0] key10 = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] pt;
    logic         busy;
`ifdef AES128_DEC_KEYOUT_EN
    logic [127:0] key0;
`endif

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   prev_acc = 0;
    exp_t sb[$];

    aes128_dec_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ct        (ct),
        .key10     (key10),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pt        (pt),
`ifdef AES128_DEC_KEYOUT_EN
        .key0      (key0),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] c, input logic [127:0] k,
                        input logic [127:0] p, input logic [127:0] k0);
        int n;
        n = 0;
        while (!in_ready && n < 30) begin
            tick();
            n++;
        end
        check("send_in_ready", {127'b0, in_ready}, 128'd1);
        in_valid = 1'b1;
        ct       = c;
        key10    = k;
        tick();
        prev_acc = acc_cyc;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        ct       = '0;
        key10    = '0;
        sb.push_back('{pt: p, key: k0});
        check("busy_after_accept", {127'b0, busy}, 128'd1);
        check("in_ready_in_round", {127'b0, in_ready}, 128'd0);
    endtask

    task automatic recv(input string tag, input int hold);
        exp_t e;
        while (!out_valid && (cyc - acc_cyc) < 20) tick();
        check({tag, "_out_valid"}, {127'b0, out_valid}, 128'd1);
        check({tag, "_latency"}, 128'(cyc - acc_cyc), 128'd10);
        if (sb.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 128'd0, 128'd1);
            e = '0;
        end else begin
            e = sb.pop_front();
        end
        check({tag, "_pt"}, pt, e.pt);
`ifdef AES128_DEC_KEYOUT_EN
        check({tag, "_key0"}, key0, e.key);
`endif
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold_pt"}, pt, e.pt);
            check({tag, "_hold_in_ready"}, {127'b0, in_ready}, 128'd0);
            check({tag, "_hold_out_valid"}, {127'b0, out_valid}, 128'd1);
        end
        out_ready = 1'b1;
        check({tag, "_done_in_ready"}, {127'b0, in_ready}, 128'd0);
        tick();
        out_ready = 1'b0;
        check({tag, "_idle_out_valid"}, {127'b0, out_valid}, 128'd0);
        check({tag, "_idle_in_ready"}, {127'b0, in_ready}, 128'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (2) tick();
        check("rst_in_ready", {127'b0, in_ready}, 128'd0);
        check("rst_out_valid", {127'b0, out_valid}, 128'd0);
        check("rst_busy", {127'b0, busy}, 128'd0);
        check("rst_pt", pt, 128'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {127'b0, in_ready}, 128'd1);
        tick();

        // Known-answer vectors, second one under backpressure
        send(C1_CT, C1_KEY10, C1_PT, C1_KEY0);
        recv("c1", 0);
        send(B_CT, B_KEY10, B_PT, B_KEY0);
        recv("b_bp", 5);

        // Reset abort at the fourth round cycle
        send(C1_CT, C1_KEY10, C1_PT, C1_KEY0);
        repeat (3) tick();
        check("abort_busy_before", {127'b0, busy}, 128'd1);
        rst = 1'b1;
        tick();
        check("abort_out_valid", {127'b0, out_valid}, 128'd0);
        check("abort_in_ready", {127'b0, in_ready}, 128'd0);
        check("abort_pt", pt, 128'd0);
        void'(sb.pop_back());
        rst = 1'b0;
        #1;
        check("abort_release_in_ready", {127'b0, in_ready}, 128'd1);
        send(C1_CT, C1_KEY10, C1_PT, C1_KEY0);
        recv("c1_after_abort", 0);

        // Request during ROUND must be ignored
        send(B_CT, B_KEY10, B_PT, B_KEY0);
        repeat (2) tick();
        in_valid = 1'b1;
        ct       = C1_CT;
        key10    = C1_KEY10;
        repeat (3) tick();
        in_valid = 1'b0;
        recv("b_ignored_req", 0);
        check("ignored_req_queue", 128'(sb.size()), 128'd0);

        // Back-to-back requests
        send(C1_CT, C1_KEY10, C1_PT, C1_KEY0);
        recv("b2b_c1", 0);
        send(B_CT, B_KEY10, B_PT, B_KEY0);
        check("b2b_spacing_ge12", {127'b0, (acc_cyc - prev_acc) >= 12}, 128'd1);
        recv("b2b_b", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
